// File: rtl/imsic_intp_file_ctrl_if.sv
// Request/response bundle between the MSI bus adapter / CSR unit (master)
// and the interrupt-file controller (slave).
interface imsic_intp_file_ctrl_if #(
  parameter int NR_FILES = 3,
  parameter int NR_SRC   = 30,
  parameter int ID_W     = $clog2(NR_SRC),
  parameter int FILE_W   = $clog2(NR_FILES)
);
  // MSI write channel
  logic              msi_valid;
  logic              msi_ready;
  logic [FILE_W-1:0] msi_file;
  logic [ID_W-1:0]   msi_id;

  // Indirect CSR channel
  logic              csr_valid;
  logic              csr_we;
  logic [FILE_W-1:0] csr_file;
  logic [1:0]        csr_sel;
  logic [31:0]       csr_wdata;
  logic [31:0]       csr_rdata;
  logic              csr_rvalid;

  modport master (
    output msi_valid, msi_file, msi_id,
    output csr_valid, csr_we, csr_file, csr_sel, csr_wdata,
    input  msi_ready, csr_rdata, csr_rvalid
  );

  modport slave (
    input  msi_valid, msi_file, msi_id,
    input  csr_valid, csr_we, csr_file, csr_sel, csr_wdata,
    output msi_ready, csr_rdata, csr_rvalid
  );
endinterface

// File: rtl/imsic_intp_file_ctrl.sv
// imsic_intp_file_ctrl: hart-side AIA interrupt-file controller.
// Holds per-file eip/eie/eithreshold/eidelivery, accepts MSI writes, serves
// an indirect CSR port and presents a registered topei/irq per file through
// a 2-stage selection pipeline.
// Optional build macro IMSIC_MSI_SKID_EN: puts a 2-entry MSI FIFO in front
// of the pending update so CSR eip writes do not stall the MSI requester.
module imsic_intp_file_ctrl #(
  parameter int NR_FILES = 3,
  parameter int NR_SRC   = 30,
  parameter int ID_W     = $clog2(NR_SRC),
  parameter int FILE_W   = $clog2(NR_FILES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  imsic_intp_file_ctrl_if.slave    bus,
  input  logic [NR_FILES-1:0]      claim_i,
  output logic [NR_FILES*ID_W-1:0] topei_o,
  output logic [NR_FILES-1:0]      irq_o
);

  typedef enum logic [1:0] {
    SEL_DELIV = 2'd0,
    SEL_THR   = 2'd1,
    SEL_EIP   = 2'd2,
    SEL_EIE   = 2'd3
  } csr_sel_e;

  // Identities 1..NR_SRC-1 are storable; bit 0 and bits >= NR_SRC read 0.
  localparam logic [63:0] SRC_ONES   = (64'd1 << NR_SRC) - 64'd1;
  localparam logic [31:0] LEGAL_MASK = SRC_ONES[31:0] & ~32'd1;

  // Architectural state
  logic [31:0]         eip_q   [NR_FILES];
  logic [31:0]         eip_d   [NR_FILES];
  logic [31:0]         eie_q   [NR_FILES];
  logic [31:0]         eie_d   [NR_FILES];
  logic [ID_W-1:0]     thr_q   [NR_FILES];
  logic [ID_W-1:0]     thr_d   [NR_FILES];
  logic [NR_FILES-1:0] deliv_q, deliv_d;

  // Selection pipeline
  logic [31:0]         mask_q  [NR_FILES];
  logic [31:0]         mask_d  [NR_FILES];
  logic [ID_W-1:0]     topei_q [NR_FILES];
  logic [ID_W-1:0]     topei_d [NR_FILES];
  logic [NR_FILES-1:0] irq_q;
  logic [NR_FILES-1:0] supp_q;     // stage-1 mask still holds a just-claimed id
  logic [NR_FILES-1:0] claim_eff;  // claim of a non-zero topei

  // CSR read response
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  // Pending-set request after MSI arbitration
  logic              set_valid;
  logic [FILE_W-1:0] set_file;
  logic [ID_W-1:0]   set_id;

  logic csr_wr, eip_wr_any, msi_fire, msi_legal;

  function automatic logic file_ok(logic [FILE_W-1:0] f);
    return int'(f) < NR_FILES;
  endfunction

  // Lowest pending identity that passes the threshold; 0 if none.
  function automatic logic [ID_W-1:0] lowest_id(logic [31:0] m, logic [ID_W-1:0] thr);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NR_SRC - 1; i >= 1; i--) begin
      if (m[i] && (thr == '0 || i < int'(thr))) r = ID_W'(i);
    end
    return r;
  endfunction

  assign csr_wr     = bus.csr_valid & bus.csr_we & file_ok(bus.csr_file);
  assign eip_wr_any = bus.csr_valid & bus.csr_we & (csr_sel_e'(bus.csr_sel) == SEL_EIP);
  assign msi_legal  = (bus.msi_id != '0) && (int'(bus.msi_id) < NR_SRC) && file_ok(bus.msi_file);

`ifdef IMSIC_MSI_SKID_EN
  logic [1:0]        cnt_q, cnt_d;
  logic [FILE_W-1:0] fq_file_q [2];
  logic [ID_W-1:0]   fq_id_q   [2];
  logic              push, pop, bypass, wr_pos;

  assign bus.msi_ready = ~rst_i & (cnt_q != 2'd2);
  assign msi_fire      = bus.msi_valid & bus.msi_ready;
  // Illegal MSIs are accepted and dropped before they occupy a slot.
  assign push          = msi_fire & msi_legal;
  // The head waits while a CSR eip write owns the pending update.
  assign pop           = (cnt_q != 2'd0) & ~eip_wr_any;
  // Empty FIFO and no collision: the MSI goes straight to the pending bits.
  assign bypass        = push & (cnt_q == 2'd0) & ~eip_wr_any;
  assign wr_pos        = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
  assign cnt_d         = cnt_q + {1'b0, push & ~bypass} - {1'b0, pop};

  assign set_valid = pop | bypass;
  assign set_file  = pop ? fq_file_q[0] : bus.msi_file;
  assign set_id    = pop ? fq_id_q[0]   : bus.msi_id;

  // FIFO occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // FIFO storage: shift on pop, then write the new tail.
  // NOTE: entry storage carries no reset; cnt_q alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      fq_file_q[0] <= fq_file_q[1];
      fq_id_q[0]   <= fq_id_q[1];
    end
    if (push && !bypass) begin
      fq_file_q[wr_pos] <= bus.msi_file;
      fq_id_q[wr_pos]   <= bus.msi_id;
    end
  end
`else
  // A concurrent CSR eip write stalls the MSI for that cycle.
  assign bus.msi_ready = ~rst_i & ~eip_wr_any;
  assign msi_fire      = bus.msi_valid & bus.msi_ready;
  assign set_valid     = msi_fire & msi_legal;
  assign set_file      = bus.msi_file;
  assign set_id        = bus.msi_id;
`endif

  // Next state of eip/eie/threshold/delivery: claim clear, then CSR write, then MSI set.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    for (int f = 0; f < NR_FILES; f++) begin
      eip_d[f]     = eip_q[f];
      eie_d[f]     = eie_q[f];
      thr_d[f]     = thr_q[f];
      deliv_d[f]   = deliv_q[f];
      claim_eff[f] = claim_i[f] & (topei_q[f] != '0);
      if (claim_eff[f]) eip_d[f][topei_q[f]] = 1'b0;
      if (csr_wr && int'(bus.csr_file) == f) begin
        case (csr_sel_e'(bus.csr_sel))
          SEL_DELIV: deliv_d[f] = bus.csr_wdata[0];
          SEL_THR:   thr_d[f]   = bus.csr_wdata[ID_W-1:0];
          SEL_EIP:   eip_d[f]   = bus.csr_wdata & LEGAL_MASK;
          SEL_EIE:   eie_d[f]   = bus.csr_wdata & LEGAL_MASK;
          default:   ;
        endcase
      end
      // Set wins over a same-cycle claim of the same identity.
      if (set_valid && int'(set_file) == f) eip_d[f][set_id] = 1'b1;
    end
  end

  // Selection pipeline next values; a claim blanks topei until the mask refreshes.
  always_comb begin
    for (int f = 0; f < NR_FILES; f++) begin
      mask_d[f]  = deliv_q[f] ? (eip_q[f] & eie_q[f]) : '0;
      topei_d[f] = (claim_eff[f] | supp_q[f]) ? '0 : lowest_id(mask_q[f], thr_q[f]);
    end
  end

  // CSR read mux; out-of-range files read as zero.
  always_comb begin
    rdata_d = '0;
    for (int f = 0; f < NR_FILES; f++) begin
      if (int'(bus.csr_file) == f) begin
        case (csr_sel_e'(bus.csr_sel))
          SEL_DELIV: rdata_d = {31'b0, deliv_q[f]};
          SEL_THR:   rdata_d = 32'(thr_q[f]);
          SEL_EIP:   rdata_d = eip_q[f];
          SEL_EIE:   rdata_d = eie_q[f];
          default:   rdata_d = '0;
        endcase
      end
    end
  end

  // State, pipeline and CSR response registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int f = 0; f < NR_FILES; f++) begin
        eip_q[f]   <= '0;
        eie_q[f]   <= '0;
        thr_q[f]   <= '0;
        mask_q[f]  <= '0;
        topei_q[f] <= '0;
      end
      deliv_q  <= '0;
      irq_q    <= '0;
      supp_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int f = 0; f < NR_FILES; f++) begin
        eip_q[f]   <= eip_d[f];
        eie_q[f]   <= eie_d[f];
        thr_q[f]   <= thr_d[f];
        mask_q[f]  <= mask_d[f];
        topei_q[f] <= topei_d[f];
        irq_q[f]   <= (topei_d[f] != '0);
      end
      deliv_q  <= deliv_d;
      supp_q   <= claim_eff;
      rvalid_q <= bus.csr_valid & ~bus.csr_we;
      if (bus.csr_valid && !bus.csr_we) rdata_q <= rdata_d;
    end
  end

  // Pack per-file topei onto the flat output bus.
  always_comb begin
    topei_o = '0;
    for (int f = 0; f < NR_FILES; f++) topei_o[f*ID_W +: ID_W] = topei_q[f];
  end

  assign irq_o          = irq_q;
  assign bus.csr_rdata  = rdata_q;
  assign bus.csr_rvalid = rvalid_q;

endmodule

// File: tb/tb_imsic_intp_file_ctrl.sv
// Self-checking bench for imsic_intp_file_ctrl: directed scenarios plus a
// randomized phase, all compared against a behavioural model of the files.
module tb_imsic_intp_file_ctrl;
  localparam int NR_FILES = 3;
  localparam int NR_SRC   = 30;
  localparam int ID_W     = 5;
  localparam int FILE_W   = 2;
  localparam logic [31:0] LEGAL = 32'h3FFF_FFFE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR_FILES-1:0]      claim;
  logic [NR_FILES*ID_W-1:0] topei;
  logic [NR_FILES-1:0]      irq;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_eip   [NR_FILES];
  logic [31:0] m_eie   [NR_FILES];
  int          m_thr   [NR_FILES];
  bit          m_deliv [NR_FILES];

  imsic_intp_file_ctrl_if #(.NR_FILES(NR_FILES), .NR_SRC(NR_SRC)) bus ();

  imsic_intp_file_ctrl #(.NR_FILES(NR_FILES), .NR_SRC(NR_SRC)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .claim_i (claim),
    .topei_o (topei),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

  // ---------------- model ----------------
  function automatic void m_reset();
    for (int f = 0; f < NR_FILES; f++) begin
      m_eip[f] = '0; m_eie[f] = '0; m_thr[f] = 0; m_deliv[f] = 1'b0;
    end
  endfunction

  function automatic void m_write(int f, int sel, logic [31:0] d);
    if (f >= NR_FILES) return;
    case (sel)
      0:       m_deliv[f] = d[0];
      1:       m_thr[f]   = int'(d[4:0]);
      2:       m_eip[f]   = d & LEGAL;
      default: m_eie[f]   = d & LEGAL;
    endcase
  endfunction

  function automatic logic [31:0] m_read(int f, int sel);
    if (f >= NR_FILES) return '0;
    case (sel)
      0:       return {31'b0, m_deliv[f]};
      1:       return 32'(m_thr[f]);
      2:       return m_eip[f];
      default: return m_eie[f];
    endcase
  endfunction

  // The lowest enabled pending id is presented only if it clears the threshold.
  function automatic int exp_topei(int f);
    if (!m_deliv[f]) return 0;
    for (int i = 1; i < NR_SRC; i++)
      if (m_eip[f][i] && m_eie[f][i]) return (m_thr[f] == 0 || i < m_thr[f]) ? i : 0;
    return 0;
  endfunction

  function automatic int dut_topei(int f);
    return int'(topei[f*ID_W +: ID_W]);
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    bus.msi_valid = 1'b0; bus.msi_file = '0; bus.msi_id = '0;
    bus.csr_valid = 1'b0; bus.csr_we = 1'b0; bus.csr_file = '0;
    bus.csr_sel = '0; bus.csr_wdata = '0;
    claim = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(int n);
    repeat (n) tick();
  endtask

  task automatic csr_write(int f, int sel, logic [31:0] d);
    bus.csr_valid = 1'b1; bus.csr_we = 1'b1;
    bus.csr_file = FILE_W'(f); bus.csr_sel = 2'(sel); bus.csr_wdata = d;
    tick();
    bus.csr_valid = 1'b0; bus.csr_we = 1'b0;
    m_write(f, sel, d);
  endtask

  task automatic csr_read(int f, int sel, output logic [31:0] d, output logic rv1, output logic rv2);
    bus.csr_valid = 1'b1; bus.csr_we = 1'b0;
    bus.csr_file = FILE_W'(f); bus.csr_sel = 2'(sel);
    tick();
    bus.csr_valid = 1'b0;
    d = bus.csr_rdata; rv1 = bus.csr_rvalid;
    tick();
    rv2 = bus.csr_rvalid;
  endtask

  // Presents an MSI and waits (bounded) for the handshake.
  task automatic msi_send(int f, int id);
    logic ok;
    bus.msi_valid = 1'b1; bus.msi_file = FILE_W'(f); bus.msi_id = ID_W'(id);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.msi_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) tick();
    bus.msi_valid = 1'b0;
    chk_cnt++;
    if (!ok) $display("FAIL msi_handshake: ready never seen for file %0d id %0d", f, id);
    else pass_cnt++;
    if (ok && f < NR_FILES && id > 0 && id < NR_SRC) m_eip[f][id] = 1'b1;
  endtask

  task automatic claim_pulse(int f);
    int e;
    e = exp_topei(f);
    claim[f] = 1'b1;
    tick();
    claim = '0;
    if (e != 0) m_eip[f][e] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); m_reset(); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (topei !== '0) $display("FAIL reset_topei: got %h want 0", topei); else pass_cnt++;
    chk_cnt++; if (irq !== '0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
    chk_cnt++; if (bus.csr_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", bus.csr_rdata); else pass_cnt++;
    chk_cnt++; if (bus.csr_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.csr_rvalid); else pass_cnt++;
    chk_cnt++; if (bus.msi_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.msi_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (bus.msi_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus.msi_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_latency();
    csr_write(0, 0, 32'h1);
    csr_write(0, 3, 32'h20);
    bus.msi_valid = 1'b1; bus.msi_file = 2'd0; bus.msi_id = 5'd5;
    tick();                       // accept edge
    bus.msi_valid = 1'b0;
    m_eip[0][5] = 1'b1;
    chk_cnt++; if (dut_topei(0) !== 0) $display("FAIL lat_plus1: got %0d want 0", dut_topei(0)); else pass_cnt++;
    tick();
    chk_cnt++; if (dut_topei(0) !== 0 || irq[0] !== 1'b0) $display("FAIL lat_plus2: got %0d/%b want 0/0", dut_topei(0), irq[0]); else pass_cnt++;
    tick();
    chk_cnt++; if (dut_topei(0) !== 5) $display("FAIL lat_plus3_topei: got %0d want 5", dut_topei(0)); else pass_cnt++;
    chk_cnt++; if (irq !== 3'b001) $display("FAIL lat_plus3_irq: got %b want 001", irq); else pass_cnt++;
    chk_cnt++; if (dut_topei(1) !== 0 || dut_topei(2) !== 0) $display("FAIL lat_other_files: got %0d,%0d want 0,0", dut_topei(1), dut_topei(2)); else pass_cnt++;
  endtask

  task automatic test_claim();
    csr_write(1, 0, 32'h1);
    csr_write(1, 3, 32'hFFFF_FFFE);
    msi_send(1, 9);
    msi_send(1, 3);
    settle(3);
    chk_cnt++; if (dut_topei(1) !== 3) $display("FAIL claim_before: got %0d want 3", dut_topei(1)); else pass_cnt++;
    claim_pulse(1);
    chk_cnt++; if (dut_topei(1) !== 0 || irq[1] !== 1'b0) $display("FAIL claim_blank1: got %0d/%b want 0/0", dut_topei(1), irq[1]); else pass_cnt++;
    tick();
    chk_cnt++; if (dut_topei(1) !== 0) $display("FAIL claim_blank2: got %0d want 0", dut_topei(1)); else pass_cnt++;
    tick();
    chk_cnt++; if (dut_topei(1) !== exp_topei(1) || dut_topei(1) !== 9) $display("FAIL claim_refresh: got %0d want 9", dut_topei(1)); else pass_cnt++;
    claim_pulse(1);
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (dut_topei(1) !== 0 || irq[1] !== 1'b0) $display("FAIL claim_empty_c%0d: got %0d/%b want 0/0", k, dut_topei(1), irq[1]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_threshold();
    csr_write(2, 0, 32'h1);
    csr_write(2, 3, 32'hFFFF_FFFE);
    csr_write(2, 1, 32'd4);
    msi_send(2, 4);
    msi_send(2, 6);
    settle(3);
    chk_cnt++; if (dut_topei(2) !== 0 || irq[2] !== 1'b0) $display("FAIL thr4: got %0d/%b want 0/0", dut_topei(2), irq[2]); else pass_cnt++;
    csr_write(2, 1, 32'd7);
    settle(2);
    chk_cnt++; if (dut_topei(2) !== 4 || irq[2] !== 1'b1) $display("FAIL thr7: got %0d/%b want 4/1", dut_topei(2), irq[2]); else pass_cnt++;
  endtask

  task automatic test_drop();
    logic [31:0] d;
    logic rv1, rv2;
    csr_write(0, 2, 32'h0);
    msi_send(0, 0);
    msi_send(0, 30);
    msi_send(3, 5);
    settle(3);
    csr_read(0, 2, d, rv1, rv2);
    chk_cnt++; if (d !== 32'h0) $display("FAIL drop_eip0: got %h want 0", d); else pass_cnt++;
    chk_cnt++; if (rv1 !== 1'b1 || rv2 !== 1'b0) $display("FAIL drop_rvalid: got %b%b want 10", rv1, rv2); else pass_cnt++;
    csr_read(3, 2, d, rv1, rv2);
    chk_cnt++; if (d !== 32'h0 || rv1 !== 1'b1) $display("FAIL drop_file3: got %h/%b want 0/1", d, rv1); else pass_cnt++;
    csr_read(2, 2, d, rv1, rv2);
    chk_cnt++; if (d !== m_read(2, 2) || d !== 32'h50) $display("FAIL drop_eip2: got %h want 50", d); else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic rv1, rv2;
    bus.csr_valid = 1'b1; bus.csr_we = 1'b1; bus.csr_file = 2'd0;
    bus.csr_sel = 2'd2; bus.csr_wdata = 32'h100;
    bus.msi_valid = 1'b1; bus.msi_file = 2'd0; bus.msi_id = 5'd5;
    #1;
`ifdef IMSIC_MSI_SKID_EN
    chk_cnt++; if (bus.msi_ready !== 1'b1) $display("FAIL coll_ready: got %b want 1", bus.msi_ready); else pass_cnt++;
    tick();
    bus.csr_valid = 1'b0; bus.csr_we = 1'b0;
    #1;
    chk_cnt++; if (bus.msi_ready !== 1'b1) $display("FAIL coll_ready_next: got %b want 1", bus.msi_ready); else pass_cnt++;
    bus.msi_valid = 1'b0;
`else
    chk_cnt++; if (bus.msi_ready !== 1'b0) $display("FAIL coll_ready: got %b want 0", bus.msi_ready); else pass_cnt++;
    tick();
    bus.csr_valid = 1'b0; bus.csr_we = 1'b0;
    #1;
    chk_cnt++; if (bus.msi_ready !== 1'b1) $display("FAIL coll_ready_next: got %b want 1", bus.msi_ready); else pass_cnt++;
    tick();
    bus.msi_valid = 1'b0;
`endif
    m_write(0, 2, 32'h100);
    m_eip[0][5] = 1'b1;
    settle(3);
    csr_read(0, 2, d, rv1, rv2);
    chk_cnt++; if (d !== 32'h120 || d !== m_read(0, 2)) $display("FAIL coll_eip: got %h want 120", d); else pass_cnt++;
    chk_cnt++; if (dut_topei(0) !== 5) $display("FAIL coll_topei: got %0d want 5", dut_topei(0)); else pass_cnt++;
  endtask

  task automatic test_claim_msi_same();
    logic [31:0] d;
    logic rv1, rv2;
    claim[0] = 1'b1;
    bus.msi_valid = 1'b1; bus.msi_file = 2'd0; bus.msi_id = 5'd5;
    #1;
    chk_cnt++; if (bus.msi_ready !== 1'b1) $display("FAIL same_ready: got %b want 1", bus.msi_ready); else pass_cnt++;
    tick();
    claim = '0; bus.msi_valid = 1'b0;
    settle(3);
    csr_read(0, 2, d, rv1, rv2);
    chk_cnt++; if (d !== 32'h120) $display("FAIL same_eip: got %h want 120", d); else pass_cnt++;
    chk_cnt++; if (dut_topei(0) !== 5) $display("FAIL same_topei: got %0d want 5", dut_topei(0)); else pass_cnt++;
  endtask

  task automatic test_random();
    int op, f, sel, id;
    logic [31:0] wd, d;
    logic rv1, rv2;
    for (int ff = 0; ff < NR_FILES; ff++) begin
      csr_write(ff, 0, 32'h1);
      csr_write(ff, 3, 32'hFFFF_FFFF);
      csr_write(ff, 1, 32'h0);
      csr_write(ff, 2, 32'h0);
    end
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 5));
      f  = int'($urandom_range(0, 3));
      case (op)
        0: begin
          sel = int'($urandom_range(0, 3));
          wd  = (sel == 1) ? 32'($urandom_range(0, 31)) : ((sel == 0) ? 32'($urandom_range(0, 7)) : $urandom());
          csr_write(f, sel, wd);
        end
        1, 2, 3: begin
          id = int'($urandom_range(0, 31));
          msi_send(f, id);
        end
        default: if (f < NR_FILES) claim_pulse(f);
      endcase
      settle(4);
      for (int ff = 0; ff < NR_FILES; ff++) begin
        chk_cnt++;
        if (dut_topei(ff) !== exp_topei(ff) || irq[ff] !== (exp_topei(ff) != 0))
          $display("FAIL rand_topei it%0d f%0d: got %0d/%b want %0d", it, ff, dut_topei(ff), irq[ff], exp_topei(ff));
        else pass_cnt++;
      end
      if (op == 0) begin
        f   = int'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 3));
        csr_read(f, sel, d, rv1, rv2);
        chk_cnt++;
        if (d !== m_read(f, sel) || rv1 !== 1'b1 || rv2 !== 1'b0)
          $display("FAIL rand_read it%0d f%0d s%0d: got %h rv%b%b want %h rv10", it, f, sel, d, rv1, rv2, m_read(f, sel));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic rv1, rv2;
    csr_write(0, 0, 32'h1);
    csr_write(0, 1, 32'h0);
    csr_write(0, 3, 32'h20);
    msi_send(0, 5);
    settle(3);
    chk_cnt++; if (dut_topei(0) !== 5) $display("FAIL mid_pre_topei: got %0d want 5", dut_topei(0)); else pass_cnt++;
    bus.csr_valid = 1'b1; bus.csr_we = 1'b0; bus.csr_file = 2'd0; bus.csr_sel = 2'd3;
    tick();
    bus.csr_valid = 1'b0;
    bus.msi_valid = 1'b1; bus.msi_file = 2'd0; bus.msi_id = 5'd7;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (topei !== '0 || irq !== '0) $display("FAIL mid_outputs: got %h/%b want 0/0", topei, irq); else pass_cnt++;
    chk_cnt++; if (bus.csr_rdata !== '0 || bus.csr_rvalid !== 1'b0) $display("FAIL mid_csr: got %h/%b want 0/0", bus.csr_rdata, bus.csr_rvalid); else pass_cnt++;
    chk_cnt++; if (bus.msi_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", bus.msi_ready); else pass_cnt++;
    @(negedge clk);
    idle();
    rst = 1'b0;
    m_reset();
    settle(3);
    csr_read(0, 2, d, rv1, rv2);
    chk_cnt++; if (d !== 32'h0 || rv1 !== 1'b1) $display("FAIL mid_eip_after: got %h/%b want 0/1", d, rv1); else pass_cnt++;
    chk_cnt++; if (topei !== '0 || irq !== '0) $display("FAIL mid_topei_after: got %h/%b want 0/0", topei, irq); else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_latency();
    test_claim();
    test_threshold();
    test_drop();
    test_collision();
    test_claim_msi_same();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
